// File: rtl/bit_packer_if.sv
// Field-in / word-out handshake bundle for bit_packer.
// The slave side is the packer; the master side is the field source and word sink.
interface bit_packer_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned LW = $clog2(W) + 1
) ();
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LW-1:0] in_len;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;

    modport master (
        output in_valid, in_data, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_len, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/bit_packer.sv
// Packs LSB-aligned variable-length fields MSB-first into W-bit words;
// a last-marked field flushes any residual bits as a zero-padded final word.
module bit_packer #(
    parameter int unsigned W  = 32,
    parameter int unsigned LW = $clog2(W) + 1
) (
    input logic         clk,
    input logic         resetn,
    bit_packer_if.slave bus
);

    typedef enum logic [0:0] {StRun, StPad} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [LW-1:0] fill_q, fill_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic          out_free;
    logic          accept;
    logic [LW-1:0] len_clamped;
    logic [W:0]    mask_wide;
    logic [W-1:0]  field;
    logic [LW:0]   total;
    logic [LW:0]   shamt;
    logic [2*W-1:0] merged;
    logic [LW-1:0] fill_after;

    assign out_free     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = resetn && (state_q == StRun) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;

    assign len_clamped = (bus.in_len > LW'(W)) ? LW'(W) : bus.in_len;
    assign mask_wide   = ((W+1)'(1) << len_clamped) - (W+1)'(1);
    assign field       = bus.in_data & mask_wide[W-1:0];
    assign total       = {1'b0, fill_q} + {1'b0, len_clamped};

    // Upper half of merged is the next output word, lower half the new residual,
    // both MSB-aligned; acc_q is kept zero below its fill bits so an OR suffices.
    assign shamt  = (LW+1)'(2 * W) - total;
    assign merged = {acc_q, {W{1'b0}}} | ({{W{1'b0}}, field} << shamt);

    always_comb begin
        fill_after = total[LW-1:0];
        if (total >= (LW+1)'(W)) begin
            fill_after = LW'(total - (LW+1)'(W));
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !bus.out_ready;

        case (state_q)
            StRun: begin
                if (accept) begin
                    fill_d = fill_after;
                    if (total >= (LW+1)'(W)) begin
                        out_data_d  = merged[2*W-1:W];
                        out_valid_d = 1'b1;
                        out_last_d  = bus.in_last && (fill_after == '0);
                        acc_d       = merged[W-1:0];
                    end else begin
                        acc_d = merged[2*W-1:W];
                    end
                    if (bus.in_last && (fill_after != '0)) begin
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                if (out_free) begin
                    out_data_d  = acc_q;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    fill_d      = '0;
                    state_d     = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StRun;
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule
